// File: rtl/fp_div_prep.sv
// Operand preparation for a Newton-Raphson binary32 divider: denormal normalization,
// quotient exponent and scaled divisor. Special-case detection compiles in with FP_DIV_PREP_SPECIAL_EN.
module fp_div_prep (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [9:0]  out_exp,
    output logic [23:0] out_a_mant,
    output logic [31:0] out_d,
    output logic        out_special,
    output logic [31:0] out_result,
    output logic        out_dz,
    output logic        out_nv
);

    typedef enum logic [1:0] {IDLE, NORM, OUT} state_t;

    state_t      state;
    logic        sign_r;
    logic [9:0]  exp_a, exp_b;
    logic [23:0] mant_a, mant_b;
    logic [4:0]  cnt;

    logic [9:0]  cap_exp_a, cap_exp_b, sh_exp_a, sh_exp_b, fin_exp_a, fin_exp_b;
    logic [23:0] cap_mant_a, cap_mant_b, sh_mant_a, sh_mant_b, fin_mant_a, fin_mant_b;
    logic        fin_sign;
    logic [4:0]  cnt_next;
    logic        finish;

    logic        is_special;
    logic [31:0] spec_result;
    logic        spec_dz, spec_nv;

    assign in_ready = (state == IDLE);

    // Capture-time view of the operands and one normalization step of the held operands;
    // fin_* selects whichever of the two feeds the output registers this cycle.
    always_comb begin
        cap_exp_a  = (a[30:23] == 8'd0) ? 10'd1 : {2'b00, a[30:23]};
        cap_exp_b  = (b[30:23] == 8'd0) ? 10'd1 : {2'b00, b[30:23]};
        cap_mant_a = {(a[30:23] != 8'd0), a[22:0]};
        cap_mant_b = {(b[30:23] != 8'd0), b[22:0]};
        sh_mant_a  = mant_a[23] ? mant_a : {mant_a[22:0], 1'b0};
        sh_mant_b  = mant_b[23] ? mant_b : {mant_b[22:0], 1'b0};
        sh_exp_a   = mant_a[23] ? exp_a : exp_a - 10'd1;
        sh_exp_b   = mant_b[23] ? exp_b : exp_b - 10'd1;
        cnt_next   = cnt + 5'd1;
        if (state == IDLE) begin
            fin_exp_a  = cap_exp_a;
            fin_exp_b  = cap_exp_b;
            fin_mant_a = cap_mant_a;
            fin_mant_b = cap_mant_b;
            fin_sign   = a[31] ^ b[31];
            finish     = in_valid && !is_special && cap_mant_a[23] && cap_mant_b[23];
        end else begin
            fin_exp_a  = sh_exp_a;
            fin_exp_b  = sh_exp_b;
            fin_mant_a = sh_mant_a;
            fin_mant_b = sh_mant_b;
            fin_sign   = sign_r;
            finish     = (state == NORM) &&
                         ((sh_mant_a[23] && sh_mant_b[23]) || (cnt_next == 5'd23));
        end
    end

`ifdef FP_DIV_PREP_SPECIAL_EN
    logic a_max, b_max, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, q_sign;

    // Priority order: NaN, invalid forms, infinite dividend, zero divisor, zero quotient.
    always_comb begin
        a_max  = (a[30:23] == 8'hFF);
        b_max  = (b[30:23] == 8'hFF);
        a_nan  = a_max && (a[22:0] != 23'd0);
        b_nan  = b_max && (b[22:0] != 23'd0);
        a_snan = a_nan && !a[22];
        b_snan = b_nan && !b[22];
        a_inf  = a_max && (a[22:0] == 23'd0);
        b_inf  = b_max && (b[22:0] == 23'd0);
        a_zero = (a[30:0] == 31'd0);
        b_zero = (b[30:0] == 31'd0);
        q_sign = a[31] ^ b[31];
        is_special  = 1'b1;
        spec_result = 32'd0;
        spec_dz     = 1'b0;
        spec_nv     = 1'b0;
        if (a_nan || b_nan) begin
            spec_result = 32'h7FC00000;
            spec_nv     = a_snan || b_snan;
        end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            spec_result = 32'h7FC00000;
            spec_nv     = 1'b1;
        end else if (a_inf) begin
            spec_result = {q_sign, 8'hFF, 23'd0};
        end else if (b_zero) begin
            spec_result = {q_sign, 8'hFF, 23'd0};
            spec_dz     = 1'b1;
        end else if (a_zero || b_inf) begin
            spec_result = {q_sign, 31'd0};
        end else begin
            is_special = 1'b0;
        end
    end
`else
    always_comb begin
        is_special  = 1'b0;
        spec_result = 32'd0;
        spec_dz     = 1'b0;
        spec_nv     = 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sign_r      <= 1'b0;
            exp_a       <= 10'd0;
            exp_b       <= 10'd0;
            mant_a      <= 24'd0;
            mant_b      <= 24'd0;
            cnt         <= 5'd0;
            out_valid   <= 1'b0;
            out_sign    <= 1'b0;
            out_exp     <= 10'd0;
            out_a_mant  <= 24'd0;
            out_d       <= 32'd0;
            out_special <= 1'b0;
            out_result  <= 32'd0;
            out_dz      <= 1'b0;
            out_nv      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= a[31] ^ b[31];
                        exp_a  <= cap_exp_a;
                        exp_b  <= cap_exp_b;
                        mant_a <= cap_mant_a;
                        mant_b <= cap_mant_b;
                        cnt    <= 5'd0;
                        if (is_special) begin
                            state       <= OUT;
                            out_valid   <= 1'b1;
                            out_sign    <= a[31] ^ b[31];
                            out_exp     <= 10'd0;
                            out_a_mant  <= 24'd0;
                            out_d       <= 32'd0;
                            out_special <= 1'b1;
                            out_result  <= spec_result;
                            out_dz      <= spec_dz;
                            out_nv      <= spec_nv;
                        end else if (!cap_mant_a[23] || !cap_mant_b[23]) begin
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    exp_a  <= sh_exp_a;
                    exp_b  <= sh_exp_b;
                    mant_a <= sh_mant_a;
                    mant_b <= sh_mant_b;
                    cnt    <= cnt_next;
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (finish) begin
                state       <= OUT;
                out_valid   <= 1'b1;
                out_sign    <= fin_sign;
                out_exp     <= fin_exp_a - fin_exp_b + 10'd126;
                out_a_mant  <= fin_mant_a;
                out_d       <= {1'b0, 8'd126, fin_mant_b[22:0]};
                out_special <= 1'b0;
                out_result  <= 32'd0;
                out_dz      <= 1'b0;
                out_nv      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_div_prep.sv
// Scoreboard bench for fp_div_prep; special-case expectations follow FP_DIV_PREP_SPECIAL_EN.
module tb_fp_div_prep;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [9:0]  out_exp;
    logic [23:0] out_a_mant;
    logic [31:0] out_d;
    logic        out_special;
    logic [31:0] out_result;
    logic        out_dz, out_nv;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sign;
        logic [9:0]  exp;
        logic [23:0] mant;
        logic [31:0] d;
        logic        special;
        logic [31:0] result;
        logic        dz;
        logic        nv;
        int          lat;
    } expect_t;

    expect_t sb[$];

    fp_div_prep dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_a_mant(out_a_mant), .out_d(out_d),
        .out_special(out_special), .out_result(out_result), .out_dz(out_dz), .out_nv(out_nv)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int lzc(input logic [23:0] m);
        int n = 0;
        for (int i = 23; i >= 0; i--) begin
            if (m[i]) return n;
            n++;
        end
        return 24;
    endfunction

    function automatic expect_t model(input logic [31:0] x, input logic [31:0] y);
        expect_t     r;
        int          ex, ey, lx, ly, k, sx, sy;
        logic [23:0] mx, my;
        ex = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
        ey = (y[30:23] == 8'd0) ? 1 : int'(y[30:23]);
        mx = {(x[30:23] != 8'd0), x[22:0]};
        my = {(y[30:23] != 8'd0), y[22:0]};
        lx = lzc(mx);
        ly = lzc(my);
        k  = (lx > ly) ? lx : ly;
        if (k > 23) k = 23;
        sx = (lx < k) ? lx : k;
        sy = (ly < k) ? ly : k;
        mx = mx << sx;
        my = my << sy;
        ex = ex - sx;
        ey = ey - sy;
        r.sign    = x[31] ^ y[31];
        r.exp     = 10'(ex - ey + 126);
        r.mant    = mx;
        r.d       = {1'b0, 8'd126, my[22:0]};
        r.special = 1'b0;
        r.result  = 32'd0;
        r.dz      = 1'b0;
        r.nv      = 1'b0;
        r.lat     = 1 + k;
`ifdef FP_DIV_PREP_SPECIAL_EN
        begin
            bit xn, yn, xs, ys, xi, yi, xz, yz, hit;
            xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
            yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
            xs = xn && (x[22] == 1'b0);
            ys = yn && (y[22] == 1'b0);
            xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
            yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
            xz = (x[30:0] == 0);
            yz = (y[30:0] == 0);
            hit = 1'b1;
            if (xn || yn) begin
                r.result = 32'h7FC00000; r.nv = xs || ys;
            end else if ((xi && yi) || (xz && yz)) begin
                r.result = 32'h7FC00000; r.nv = 1'b1;
            end else if (xi) begin
                r.result = r.sign ? 32'hFF800000 : 32'h7F800000;
            end else if (yz) begin
                r.result = r.sign ? 32'hFF800000 : 32'h7F800000; r.dz = 1'b1;
            end else if (xz || yi) begin
                r.result = r.sign ? 32'h80000000 : 32'h00000000;
            end else begin
                hit = 1'b0;
            end
            if (hit) begin
                r.special = 1'b1;
                r.exp     = 10'd0;
                r.mant    = 24'd0;
                r.d       = 32'd0;
                r.lat     = 1;
            end
        end
`endif
        return r;
    endfunction

    // Issues one operation, keeps noisy in_valid high while busy, then holds out_ready low for 'hold' cycles.
    task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb, input int hold);
        expect_t e;
        int      n;
        checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
        a = ta;
        b = tb;
        in_valid = 1'b1;
        sb.push_back(model(ta, tb));
        @(posedge clk);
        @(negedge clk);
        n = 1;
        a = $urandom;
        b = $urandom;
        while (!out_valid && n < 60) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        if (!out_valid) begin
            checkOutput("timeout", 32'(out_valid), 32'd1);
        end else begin
            checkOutput("latency", 32'(n), 32'(e.lat));
            checkOutput("sign", 32'(out_sign), 32'(e.sign));
            checkOutput("exp", 32'(out_exp), 32'(e.exp));
            checkOutput("a_mant", 32'(out_a_mant), 32'(e.mant));
            checkOutput("d", out_d, e.d);
            checkOutput("special", 32'(out_special), 32'(e.special));
            checkOutput("result", out_result, e.result);
            checkOutput("dz", 32'(out_dz), 32'(e.dz));
            checkOutput("nv", 32'(out_nv), 32'(e.nv));
            checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            checkOutput("hold_exp", 32'(out_exp), 32'(e.exp));
            checkOutput("hold_a_mant", 32'(out_a_mant), 32'(e.mant));
            checkOutput("hold_d", out_d, e.d);
            checkOutput("hold_result", out_result, e.result);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("release_valid", 32'(out_valid), 32'd0);
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        int          ghosts;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_exp", 32'(out_exp), 32'd0);
        checkOutput("rst_d", out_d, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_valid_after", 32'(out_valid), 32'd0);

        applyStimulus(32'h40400000, 32'h40000000, 0);
        applyStimulus(32'h3F800000, 32'h00000001, 0);
        applyStimulus(32'h00000000, 32'h00000000, 0);
        applyStimulus(32'h00400000, 32'h3F800000, 0);
        applyStimulus(32'hC0A00000, 32'h3FC00000, 5);
        applyStimulus(32'h80000000, 32'h3F800000, 0);
        applyStimulus(32'h3F800000, 32'h80000000, 0);
        applyStimulus(32'h7F800000, 32'h7F800000, 0);
        applyStimulus(32'h7F800001, 32'h3F800000, 0);
        applyStimulus(32'h7FC00000, 32'h3F800000, 0);
        applyStimulus(32'h3F800000, 32'h7F800000, 0);
        applyStimulus(32'h7F800000, 32'h40000000, 0);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            ra[30:23] = 8'($urandom_range(1, 254));
            rb[30:23] = (i % 3 == 0) ? 8'd0 : 8'($urandom_range(1, 254));
            if (i % 3 == 0) rb[22:0] = rb[22:0] | 23'd1;
            applyStimulus(ra, rb, i % 2);
        end

        // Reset in the middle of normalization must drop the operation entirely.
        a        = 32'h3F800000;
        b        = 32'h00000001;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("norm_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        ghosts = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) ghosts++;
        end
        checkOutput("no_ghost_output", 32'(ghosts), 32'd0);

        applyStimulus(32'h40400000, 32'h40000000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_div_prep.md
FP_DIV_PREP -- requirements
Module: fp_div_prep

Interface
REQ-001 Parameters: none; all widths are fixed to IEEE-754 binary32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair a/b present.
REQ-005 in_ready  output  1  block can accept operands; high only in IDLE.
REQ-006 a  input  32  dividend, binary32.
REQ-007 b  input  32  divisor, binary32.
REQ-008 out_valid  output  1  prepared operands or special result available.
REQ-009 out_ready  input  1  downstream Newton-Raphson divider accepts the result.
REQ-010 out_sign  output  1  a[31] XOR b[31].
REQ-011 out_exp  output  10  signed biased quotient exponent, Ea_eff - Eb_eff + 126.
REQ-012 out_a_mant  output  24  normalized dividend mantissa, bit 23 = 1.
REQ-013 out_d  output  32  scaled divisor {1'b0, 8'd126, normalized b fraction[22:0]}, value in [0.5,1).
REQ-014 out_special  output  1  out_result is final; downstream skips the iteration.
REQ-015 out_result  output  32  special-case quotient; 0 when out_special = 0.
REQ-016 out_dz / out_nv  output  1 each  divide-by-zero and invalid-operation flags.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, NORM and OUT.
REQ-018 In IDLE, a cycle with in_valid=1 SHALL capture a and b.
- Exponent field 0: effective exponent = 1, implicit bit = 0.
- Otherwise: effective exponent = field, implicit bit = 1.
REQ-019 Next state after capture:
- Special case (REQ-024): OUT.
- Either captured mantissa has bit 23 = 0: NORM.
- Otherwise: OUT.
REQ-020 In NORM, each cycle, every mantissa whose bit 23 is 0 SHALL shift left by 1 and decrement its effective exponent by 1.
REQ-021 NORM SHALL exit to OUT when both mantissas have bit 23 set or when a 5-bit shift counter reaches 23, whichever comes first.
REQ-022 Latency from the capture edge to out_valid=1:
- Normal operands or special case: 1 cycle.
- Denormal operands: 1+k cycles, where k = max leading-zero count (at most 23).
REQ-023 In OUT, out_valid SHALL be 1 and all outputs SHALL hold stable until out_ready=1. On that cycle the FSM returns to IDLE. Throughput is at most one operation per 2 cycles.
REQ-024 Special-case priority (only when the macro is defined):
- Either operand NaN: 0x7FC00000; nv=1 if either operand is an sNaN.
- inf/inf or 0/0: 0x7FC00000, nv=1.
- a inf: signed infinity.
- b zero: signed infinity, dz=1.
- a zero or b inf: signed zero.
REQ-025 out_exp SHALL be computed in 10-bit signed arithmetic with no clamping; overflow and underflow handling belongs downstream.
REQ-026 in_valid asserted outside IDLE SHALL be ignored; the source holds it per the valid/ready rule.

Reset
REQ-027 While rst=1 (asynchronously), the state SHALL be IDLE and every output register SHALL be 0, so out_valid=0 and in_ready=1 after release.
REQ-028 Reset during NORM or OUT SHALL discard the in-flight operation with no output produced.

Configuration
REQ-029 Macro FP_DIV_PREP_SPECIAL_EN, when defined, SHALL compile in special-case detection per REQ-024.
REQ-030 When FP_DIV_PREP_SPECIAL_EN is undefined:
- out_special, out_result, out_dz and out_nv SHALL be tied to 0.
- All operands SHALL take the normal/NORM path.
- Zero operands SHALL be bounded by the 23-shift cap.

Verification
REQ-031 a=0x40400000, b=0x40000000 -> 1 cycle later: out_exp=126, out_a_mant=0xC00000, out_d=0x3F000000, out_sign=0, out_special=0.
REQ-032 a=0x3F800000, b=0x00000001 -> out_valid 24 cycles after capture: out_exp=275, out_a_mant=0x800000, out_d=0x3F000000.
REQ-033 With the macro defined, a=0x3F800000, b=0x80000000 -> 1 cycle later: out_special=1, out_result=0xFF800000, out_dz=1, out_nv=0.
REQ-034 With the macro defined, a=0x00000000, b=0x00000000 -> out_result=0x7FC00000, out_nv=1.
- Same operands with the macro undefined -> out_special=0, out_valid after exactly 24 cycles.
REQ-035 Backpressure and reset:
- Hold out_ready=0 for 5 cycles in OUT -> outputs stable, in_ready=0.
- Assert rst mid-NORM -> out_valid=0 and in_ready=1 immediately, and no output appears afterwards.
